// File: rtl/spi_slave_port_if.sv
// CPU register-bus and external SPI pin bundle for spi_slave_port.
// The master modport is the system side (CPU bus plus external SPI master); slave is the port itself.
interface spi_slave_port_if;
    logic [7:0] addr;
    logic       ior;
    logic       iow;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe_n;
    logic       irq;
    logic       slv_cs_n;
    logic       slv_sclk;
    logic       slv_mosi;
    logic       slv_miso;

    modport master (
        output addr, ior, iow, din, slv_cs_n, slv_sclk, slv_mosi,
        input  dout, oe_n, irq, slv_miso
    );

    modport slave (
        input  addr, ior, iow, din, slv_cs_n, slv_sclk, slv_mosi,
        output dout, oe_n, irq, slv_miso
    );
endinterface

// File: rtl/spi_slave_port.sv
// Oversampled SPI mode-0 responder exchanging bytes with the Z80 via two ZXUNO registers.
// Optional feature macro: SPI_SLAVE_RXFIFO_EN (4-entry RX FIFO instead of one holding register).
module spi_slave_port #(
    parameter logic [7:0] DATAREG = 8'hC6,
    parameter logic [7:0] STATREG = 8'hC7
) (
    input logic           clk,
    input logic           rst,
    spi_slave_port_if.slave bus
);

    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic       mosi_meta_q, mosi_sync_q;
    logic [2:0] fill_q;
    logic       ior_q, iow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b1;
            mosi_sync_q <= 1'b1;
            fill_q      <= 3'b000;
            ior_q       <= 1'b0;
            iow_q       <= 1'b0;
        end else begin
            cs_meta_q   <= bus.slv_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sclk_meta_q <= bus.slv_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= bus.slv_mosi;
            mosi_sync_q <= mosi_meta_q;
            fill_q      <= {fill_q[1:0], 1'b1};
            ior_q       <= bus.ior;
            iow_q       <= bus.iow;
        end
    end

    logic       in_frame_q, in_frame_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_full_q, tx_full_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       tx_und_q, tx_und_d;

    logic       armed, cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic       commit, reload;
    logic [7:0] rx_byte;
    logic       pop_req, wr_rise, data_wr, stat_wr;
    logic       rx_valid, ovr_set;
    logic [7:0] rx_head;
    logic [1:0] occ;
    logic [7:0] status;

    // Edges are ignored until the sync chain holds real pin samples after reset, so a cs
    // held low through reset is not mistaken for a new frame start.
    assign armed     = fill_q[2];
    assign cs_fall   = armed & cs_prev_q & ~cs_sync_q;
    assign cs_rise   = armed & ~cs_prev_q & cs_sync_q;
    assign sclk_rise = in_frame_q & ~sclk_prev_q & sclk_sync_q;
    assign sclk_fall = in_frame_q & sclk_prev_q & ~sclk_sync_q;
    assign commit    = sclk_rise & ~cs_rise & (cnt_q == 3'd7);
    assign reload    = cs_fall | commit;
    assign rx_byte   = {rx_sh_q[6:0], mosi_sync_q};

    assign pop_req = ior_q & ~bus.ior & (bus.addr == DATAREG);
    assign wr_rise = bus.iow & ~iow_q;
    assign data_wr = wr_rise & (bus.addr == DATAREG);
    assign stat_wr = wr_rise & (bus.addr == STATREG);

    always_comb begin
        in_frame_d = in_frame_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        rx_ovr_d   = rx_ovr_q;
        tx_und_d   = tx_und_q;

        if (cs_fall) begin
            in_frame_d = 1'b1;
            cnt_d      = 3'd0;
        end else if (cs_rise) begin
            in_frame_d = 1'b0;
            cnt_d      = 3'd0;
        end else if (sclk_rise) begin
            rx_sh_d = rx_byte;
            cnt_d   = cnt_q + 3'd1;
        end else if (sclk_fall && cnt_q != 3'd0) begin
            // The falling edge right after a byte reload keeps the fresh MSB on the line.
            tx_sh_d = {tx_sh_q[6:0], 1'b1};
        end

        if (stat_wr) begin
            if (bus.din[2]) rx_ovr_d = 1'b0;
            if (bus.din[3]) tx_und_d = 1'b0;
        end

        if (reload) begin
            if (tx_full_q) begin
                tx_sh_d   = tx_hold_q;
                tx_full_d = 1'b0;
            end else begin
                tx_sh_d  = 8'hFF;
                tx_und_d = 1'b1;
            end
        end

        if (ovr_set) rx_ovr_d = 1'b1;

        // A CPU write in the same cycle as a reload lands after it.
        if (data_wr) begin
            tx_hold_d = bus.din;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame_q <= 1'b0;
            cnt_q      <= 3'd0;
            rx_sh_q    <= 8'hFF;
            tx_sh_q    <= 8'hFF;
            tx_hold_q  <= 8'hFF;
            tx_full_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_und_q   <= 1'b0;
        end else begin
            in_frame_q <= in_frame_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_und_q   <= tx_und_d;
        end
    end

`ifdef SPI_SLAVE_RXFIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] rd_ptr_q, wr_ptr_q;
    logic [2:0] count_q;
    logic       pop, push;

    assign rx_valid = (count_q != 3'd0);
    assign pop      = pop_req & rx_valid;
    assign push     = commit & ((count_q != 3'd4) | pop);
    assign ovr_set  = commit & ~push;
    assign rx_head  = fifo_q[rd_ptr_q];
    assign occ      = rx_valid ? (count_q[1:0] - 2'd1) : 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 8'hFF;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rx_byte;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end
`else
    logic [7:0] rx_hold_q, rx_hold_d;
    logic       rx_valid_q, rx_valid_d;
    logic       pop;

    assign rx_valid = rx_valid_q;
    assign pop      = pop_req & rx_valid_q;
    assign rx_head  = rx_hold_q;
    assign occ      = 2'd0;
    assign ovr_set  = commit & rx_valid_q & ~pop;

    always_comb begin
        rx_hold_d  = rx_hold_q;
        rx_valid_d = rx_valid_q;
        if (commit && !ovr_set) begin
            rx_hold_d  = rx_byte;
            rx_valid_d = 1'b1;
        end else if (pop) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold_q  <= 8'hFF;
            rx_valid_q <= 1'b0;
        end else begin
            rx_hold_q  <= rx_hold_d;
            rx_valid_q <= rx_valid_d;
        end
    end
`endif

    assign status = {1'b0, occ, ~cs_sync_q, tx_und_q, rx_ovr_q, ~tx_full_q, rx_valid};

    assign bus.dout     = (bus.addr == STATREG) ? status : (rx_valid ? rx_head : 8'hFF);
    assign bus.oe_n     = ~(bus.ior & ((bus.addr == DATAREG) | (bus.addr == STATREG)));
    assign bus.irq      = rx_valid;
    assign bus.slv_miso = tx_sh_q[7];

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed plus randomized bench for spi_slave_port against a byte-level queue model.
module tb_spi_slave_port;

    localparam logic [7:0] DATAREG = 8'hC6;
    localparam logic [7:0] STATREG = 8'hC7;
`ifdef SPI_SLAVE_RXFIFO_EN
    localparam int RX_DEPTH = 4;
`else
    localparam int RX_DEPTH = 1;
`endif

    logic clk;
    logic rst;
    spi_slave_port_if bus ();

    spi_slave_port #(
        .DATAREG(DATAREG),
        .STATREG(STATREG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte queue for RX, one TX holding slot, sticky flags.
    logic [7:0] m_rxq[$];
    logic       m_tx_full;
    logic [7:0] m_tx_val;
    logic       m_ovr, m_und;

    task automatic m_reset();
        m_rxq.delete();
        m_tx_full = 1'b0;
        m_tx_val  = 8'hFF;
        m_ovr     = 1'b0;
        m_und     = 1'b0;
    endtask

    function automatic logic [7:0] m_tx_take();
        logic [7:0] v;
        if (m_tx_full) begin
            v = m_tx_val;
            m_tx_full = 1'b0;
        end else begin
            v = 8'hFF;
            m_und = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] m_status(input logic cs_act);
        logic [1:0] o;
        o = (m_rxq.size() > 0) ? 2'(m_rxq.size() - 1) : 2'd0;
        return {1'b0, o, cs_act, m_und, m_ovr, ~m_tx_full, (m_rxq.size() != 0)};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        bus.addr = a;
        bus.ior  = 1'b1;
        repeat (2) @(negedge clk);
        d  = bus.dout;
        oe = bus.oe_n;
        bus.ior = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.iow  = 1'b1;
        repeat (2) @(negedge clk);
        bus.iow = 1'b0;
        repeat (2) @(negedge clk);
        if (a == DATAREG) begin
            m_tx_full = 1'b1;
            m_tx_val  = d;
        end else if (a == STATREG) begin
            if (d[2]) m_ovr = 1'b0;
            if (d[3]) m_und = 1'b0;
        end
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        bus.slv_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            bus.slv_mosi = mo[7-i];
            repeat (4) @(negedge clk);
            mi[7-i] = bus.slv_miso;
            bus.slv_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.slv_sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        bus.slv_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] mo, input int n);
        logic [7:0] exp_mi, mi, mask;
        exp_mi = m_tx_take();
        spi_bits(mo, n, mi);
        spi_end();
        if (n == 8) begin
            if (m_rxq.size() < RX_DEPTH) m_rxq.push_back(mo);
            else m_ovr = 1'b1;
            void'(m_tx_take());
        end
        mask = 8'hFF << (8 - n);
        check({tag, "_miso"}, mi & mask, exp_mi & mask);
        check({tag, "_irq"}, 8'(bus.irq), 8'(m_rxq.size() != 0));
    endtask

    task automatic do_data_read(input string tag);
        logic [7:0] d, exp;
        logic oe;
        exp = (m_rxq.size() != 0) ? m_rxq.pop_front() : 8'hFF;
        cpu_read(DATAREG, d, oe);
        check({tag, "_dout"}, d, exp);
        check({tag, "_oe_n"}, 8'(oe), 8'h00);
        check({tag, "_irq_after"}, 8'(bus.irq), 8'(m_rxq.size() != 0));
    endtask

    task automatic do_stat_read(input string tag, input logic cs_act, output logic [7:0] d);
        logic oe;
        cpu_read(STATREG, d, oe);
        check({tag, "_stat"}, d, m_status(cs_act));
        check({tag, "_oe_n"}, 8'(oe), 8'h00);
    endtask

    initial begin
        logic [7:0] st, mi;
        rst = 1'b1;
        bus.addr = 8'h00;
        bus.ior = 1'b0;
        bus.iow = 1'b0;
        bus.din = 8'h00;
        bus.slv_cs_n = 1'b1;
        bus.slv_sclk = 1'b0;
        bus.slv_mosi = 1'b1;
        m_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Idle after reset
        check("reset_miso", 8'(bus.slv_miso), 8'h01);
        check("reset_irq", 8'(bus.irq), 8'h00);
        check("idle_oe_n", 8'(bus.oe_n), 8'h01);
        do_stat_read("reset", 1'b0, st);
        check("reset_stat_const", st, 8'h02);
        do_data_read("empty");

        // CPU TX A5 while master sends 3C
        cpu_write(DATAREG, 8'hA5);
        do_frame("a5_3c", 8'h3C, 8);
        check("a5_3c_irq_const", 8'(bus.irq), 8'h01);
        do_data_read("rd_3c");
        do_stat_read("after_3c", 1'b0, st);

        // Two frames with TX empty and no read in between
        do_frame("empty_tx1", 8'h11, 8);
        do_frame("empty_tx2", 8'h22, 8);
        do_stat_read("two_frames", 1'b0, st);
        cpu_write(STATREG, 8'h0C);
        do_stat_read("flags_cleared", 1'b0, st);
        repeat (3) do_data_read("drain");

        // Five bytes back to back: fills the FIFO when present
        for (int i = 1; i <= 5; i++) do_frame("burst", 8'(i), 8);
        do_stat_read("burst", 1'b0, st);
        for (int i = 0; i < 5; i++) do_data_read("burst_rd");
        cpu_write(STATREG, 8'h0C);

        // Aborted frame, then a full one
        do_frame("partial", 8'hAA, 5);
        do_stat_read("partial", 1'b0, st);
        do_frame("after_partial", 8'h81, 8);
        do_data_read("rd_81");

        // Reset in the middle of a frame
        cpu_write(DATAREG, 8'h96);
        begin
            logic [7:0] exp_mi, mask;
            exp_mi = m_tx_take();
            spi_bits(8'hC3, 4, mi);
            mask = 8'hF0;
            check("midframe_miso", mi & mask, exp_mi & mask);
            do_stat_read("midframe", 1'b1, st);
        end
        rst = 1'b1;
        bus.slv_cs_n = 1'b1;
        bus.slv_sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (6) @(negedge clk);
        check("post_rst_miso", 8'(bus.slv_miso), 8'h01);
        do_stat_read("post_rst", 1'b0, st);
        check("post_rst_stat_const", st, 8'h02);
        do_frame("post_rst", 8'h5A, 8);
        do_data_read("rd_5a");

        // Randomized mix of bus and SPI activity
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: cpu_write(DATAREG, 8'($urandom));
                1: do_frame("rnd_full", 8'($urandom), 8);
                2: do_frame("rnd_part", 8'($urandom), int'($urandom_range(1, 7)));
                3: do_data_read("rnd_rd");
                4: do_stat_read("rnd_st", 1'b0, st);
                default: cpu_write(STATREG, 8'($urandom));
            endcase
        end
        do_stat_read("final", 1'b0, st);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
